rb_sequencer: RTL and testbench
===============================

// Module: rb_sequencer
// PURPOSE
//  Initiator-side controller for the 8x32 register bank: accepts one instruction
//  word, drives src1/src2 read addresses, captures operands A/B, computes Z,
//  writes back via WR/dest and completes on the bank's DONE. Sits between the
//  instruction source (testbench or fetch unit) and reg_bank in the datapath.
// PARAMETERS
//  DW          32  data width of A, B, Z
//  AW          3   register address width (8 registers)
//  DONE_TMO    4   cycles to wait for DONE after a write before flagging err
//  CNTW        16  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, all state on posedge
//  rst          in   1      asynchronous, active-high reset
//  instr_valid  in   1      instruction word present
//  instr        in   16     [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] rsvd (ignored)
//  instr_ready  out  1      high only in IDLE; accept when valid&&ready at posedge
//  src1,src2    out  AW     read addresses to bank (rs, rt)
//  A,B          in   DW     operands from bank (bank samples on negedge)
//  dest         out  AW     write address (rd)
//  Z            out  DW     write data
//  WR           out  1      write strobe, exactly one cycle per writing op
//  DONE         in   1      bank write acknowledge
//  result       out  DW     copy of last Z, held until next completion
//  result_valid out  1      one-cycle completion pulse
//  err          out  1      one-cycle pulse: illegal op or DONE timeout
//  retired      out  CNTW   count of result_valid pulses, wraps at 2^CNTW
// BEHAVIOUR
//  Reset: all outputs 0 (src1,src2,dest,Z,WR,result,result_valid,err,retired);
//   instr_ready 1 after reset deasserts; state IDLE. Reset mid-op drops WR at once.
//  States: IDLE -> READ -> WB -> ACK -> IDLE.
//  T0 IDLE: accept; register op/rd; drive src1=rs, src2=rt. -> READ.
//   Bank captures A/B on the negedge inside T0..T1.
//  T1 READ: compute Z=f(op,A,B), register Z, dest=rd, WR=1 -> WB.
//   NOP: no WR, result_valid at T1, -> IDLE. Illegal op: err pulse, no WR, -> IDLE.
//  T2 WB: bank writes on this posedge; WR<=0 -> ACK; timeout counter cleared.
//  ACK: DONE==1 -> result<=Z, result_valid pulse, retired++, -> IDLE.
//   DONE==0 for DONE_TMO cycles -> err pulse, no result_valid, -> IDLE.
//  Latency accept->result_valid: 3 cycles nominal; next accept 1 cycle later.
//  Ops (DW-bit, wrap modulo 2^DW, no flags): 0 NOP, 1 ADD, 2 SUB (A-B), 3 AND,
//   4 OR, 5 XOR, 6 NOT A, 7 SLL A<<B[4:0], 8 SRL, 9 SRA (sign of A[DW-1]),
//   10 SLT signed (Z=1/0), 11 MOV (Z=A); 12-15 illegal.
//  rd==rs or rd==rt legal: operands captured before the write.
//  instr and instr_valid ignored outside IDLE; no queueing.
//  src1/src2/dest hold their last value when idle.
// STRUCTURE
//  Shared header/package: opcode constants OP_NOP..OP_MOV, state encodings,
//   instr field bit positions.
//  One sub-module: rb_alu (combinational, op/A/B -> Z, illegal flag).
//  FSM, timeout counter, retired counter and output registers in rb_sequencer.
// TESTING (bank after reset holds Ri=i)
//  ADD rd=3 rs=1 rt=2 -> WR 1 cycle, dest=3, Z=3, result_valid 3 cycles after accept.
//  SUB rd=0 rs=0 rt=1 -> Z=32'hFFFF_FFFF; SRA then on R0 by R1 -> Z=32'hFFFF_FFFF.
//  Op 13 -> err pulse, WR never high, instr_ready back next cycle, retired unchanged.
//  Back-to-back ADD r4=r4+r4 x3 (valid held) -> Z=8,16,32; retired=3.
//  Assert rst during WB -> WR low immediately, all outputs 0, bank contents re-init.
//  Tie DONE low -> err after DONE_TMO cycles in ACK, no result_valid, return to IDLE.

Source files
------------

// File: rtl/rb_sequencer_pkg.sv
// Shared definitions for the register-bank sequencer: FSM state encoding,
// opcode constants and instruction field positions.
package rb_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WB   = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP = 4'd0;
    localparam opcode_t OP_ADD = 4'd1;
    localparam opcode_t OP_SUB = 4'd2;
    localparam opcode_t OP_AND = 4'd3;
    localparam opcode_t OP_OR  = 4'd4;
    localparam opcode_t OP_XOR = 4'd5;
    localparam opcode_t OP_NOT = 4'd6;
    localparam opcode_t OP_SLL = 4'd7;
    localparam opcode_t OP_SRL = 4'd8;
    localparam opcode_t OP_SRA = 4'd9;
    localparam opcode_t OP_SLT = 4'd10;
    localparam opcode_t OP_MOV = 4'd11;

    // Instruction word layout: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] reserved
    localparam int INSTR_W = 16;
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int RT_LSB  = 3;
    localparam int RSVD_W  = 3;

endpackage

// File: rtl/rb_alu.sv
// Combinational ALU for the sequencer: computes Z from op/A/B with modulo
// 2^DW wrap and flags opcodes 12-15 as illegal.
module rb_alu
    import rb_sequencer_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] z_o,
    output logic          illegal_o
);

    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] b_s;
    logic [4:0]           shamt;

    assign a_s   = a_i;
    assign b_s   = b_i;
    assign shamt = b_i[4:0];

    // Opcode decode; NOP yields zero and leaves the write-back decision to the FSM
    always_comb begin
        z_o       = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_NOP: z_o = '0;
            OP_ADD: z_o = a_i + b_i;
            OP_SUB: z_o = a_i - b_i;
            OP_AND: z_o = a_i & b_i;
            OP_OR:  z_o = a_i | b_i;
            OP_XOR: z_o = a_i ^ b_i;
            OP_NOT: z_o = ~a_i;
            OP_SLL: z_o = a_i << shamt;
            OP_SRL: z_o = a_i >> shamt;
            OP_SRA: z_o = a_s >>> shamt;
            OP_SLT: z_o = {{(DW-1){1'b0}}, (a_s < b_s)};
            OP_MOV: z_o = a_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rb_sequencer.sv
// Initiator-side controller for the 8x32 register bank: accepts an
// instruction, reads rs/rt, computes Z, writes back to rd and waits for
// the bank's DONE (bounded by DONE_TMO) before reporting completion.
module rb_sequencer
    import rb_sequencer_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 3,
    parameter int DONE_TMO = 4,
    parameter int CNTW     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [AW-1:0]      src1,
    output logic [AW-1:0]      src2,
    input  logic [DW-1:0]      A,
    input  logic [DW-1:0]      B,
    output logic [AW-1:0]      dest,
    output logic [DW-1:0]      Z,
    output logic               WR,
    input  logic               DONE,
    output logic [DW-1:0]      result,
    output logic               result_valid,
    output logic               err,
    output logic [CNTW-1:0]    retired
);

    localparam int TW = $clog2(DONE_TMO + 1);

    state_t          state_q;
    opcode_t         op_q;
    logic [AW-1:0]   rd_q;
    logic [TW-1:0]   tmo_q;
    logic [DW-1:0]   z_d;
    logic            alu_illegal;
    logic            unused_rsvd;

    // Reserved instruction bits carry no meaning
    assign unused_rsvd = ^instr[RSVD_W-1:0];

    assign instr_ready = (state_q == S_IDLE);

    rb_alu #(
        .DW (DW)
    ) u_alu (
        .op_i      (op_q),
        .a_i       (A),
        .b_i       (B),
        .z_o       (z_d),
        .illegal_o (alu_illegal)
    );

    // Sequencer FSM with timeout/retired counters and registered bank/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_NOP;
            rd_q         <= '0;
            tmo_q        <= '0;
            src1         <= '0;
            src2         <= '0;
            dest         <= '0;
            Z            <= '0;
            WR           <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            retired      <= '0;
        end else begin
            result_valid <= 1'b0;
            err          <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q    <= instr[OP_LSB +: OP_W];
                        rd_q    <= instr[RD_LSB +: AW];
                        src1    <= instr[RS_LSB +: AW];
                        src2    <= instr[RT_LSB +: AW];
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // A/B were sampled by the bank on the negedge after accept
                    if (alu_illegal) begin
                        err     <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (op_q == OP_NOP) begin
                        result_valid <= 1'b1;
                        retired      <= retired + CNTW'(1);
                        state_q      <= S_IDLE;
                    end else begin
                        Z       <= z_d;
                        dest    <= rd_q;
                        WR      <= 1'b1;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    WR      <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    if (DONE) begin
                        result       <= Z;
                        result_valid <= 1'b1;
                        retired      <= retired + CNTW'(1);
                        state_q      <= S_IDLE;
                    end else if (tmo_q == TW'(DONE_TMO - 1)) begin
                        err     <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rb_sequencer.sv
// Directed bench for rb_sequencer with a behavioural 8x32 register bank
// (Ri=i after reset, negedge operand capture, one-cycle DONE after WR).
module tb_rb_sequencer;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  src1, src2, dest;
    logic [31:0] A, B, Z, result;
    logic        WR, DONE, result_valid, err;
    logic [15:0] retired;

    logic [31:0] mem [8];
    logic        done_en;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    rb_sequencer #(
        .DW       (32),
        .AW       (3),
        .DONE_TMO (4),
        .CNTW     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .src1         (src1),
        .src2         (src2),
        .A            (A),
        .B            (B),
        .dest         (dest),
        .Z            (Z),
        .WR           (WR),
        .DONE         (DONE),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: write on posedge WR, acknowledge next cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'(i);
            DONE <= 1'b0;
        end else begin
            if (WR) mem[dest] <= Z;
            DONE <= WR && done_en;
        end
    end

    // Bank operand capture on negedge
    always @(negedge clk) begin
        A <= mem[src1];
        B <= mem[src2];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    // One full writing instruction: accept, T1 write strobe, WB, ACK completion
    task automatic exec_op(input string tag, input logic [15:0] ins, input logic [31:0] exp_z);
        logic [2:0] rd;
        rd = ins[11:9];
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check({tag, "_ready_low"}, instr_ready, 1'b0);
        check({tag, "_src1"}, src1, ins[8:6]);
        check({tag, "_src2"}, src2, ins[5:3]);
        tick();
        check({tag, "_wr_t1"}, WR, 1'b1);
        check({tag, "_dest"}, dest, rd);
        check({tag, "_z"}, Z, exp_z);
        check({tag, "_rv_t1"}, result_valid, 1'b0);
        tick();
        check({tag, "_wr_t2"}, WR, 1'b0);
        check({tag, "_bank"}, mem[rd], exp_z);
        tick();
        exp_ret++;
        check({tag, "_rv"}, result_valid, 1'b1);
        check({tag, "_result"}, result, exp_z);
        check({tag, "_retired"}, retired, 32'(exp_ret));
        check({tag, "_ready"}, instr_ready, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        done_en     = 1'b1;
        tick();
        tick();
        check("rst_wr", WR, 1'b0);
        check("rst_z", Z, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_rv", result_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_retired", retired, 32'h0);
        check("rst_src", {src1, src2, dest}, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_ready", instr_ready, 1'b1);

        exec_op("add", mk(4'd1, 3'd3, 3'd1, 3'd2), 32'h0000_0003);
        tick();
        check("add_rv_drop", result_valid, 1'b0);
        check("add_result_hold", result, 32'h0000_0003);
        check("add_wr_once", WR, 1'b0);

        exec_op("sub", mk(4'd2, 3'd0, 3'd0, 3'd1), 32'hFFFF_FFFF);
        exec_op("sra", mk(4'd9, 3'd5, 3'd0, 3'd1), 32'hFFFF_FFFF);
        exec_op("srl", mk(4'd8, 3'd6, 3'd0, 3'd2), 32'h3FFF_FFFF);
        exec_op("slt", mk(4'd10, 3'd7, 3'd0, 3'd1), 32'h0000_0001);
        exec_op("and", mk(4'd3, 3'd2, 3'd6, 3'd3), 32'h0000_0003);
        exec_op("sll", mk(4'd7, 3'd3, 3'd3, 3'd7), 32'h0000_0006);
        exec_op("or",  mk(4'd4, 3'd6, 3'd3, 3'd7), 32'h0000_0007);
        exec_op("xor", mk(4'd5, 3'd1, 3'd6, 3'd3), 32'h0000_0001);
        exec_op("not", mk(4'd6, 3'd5, 3'd5, 3'd0), 32'h0000_0000);
        exec_op("mov", mk(4'd11, 3'd5, 3'd3, 3'd0), 32'h0000_0006);

        // NOP completes at T1 without a write
        instr       = mk(4'd0, 3'd2, 3'd1, 3'd1);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("nop_wr_t0", WR, 1'b0);
        tick();
        exp_ret++;
        check("nop_rv", result_valid, 1'b1);
        check("nop_wr_t1", WR, 1'b0);
        check("nop_retired", retired, 32'(exp_ret));
        check("nop_result_hold", result, 32'h0000_0006);
        check("nop_ready", instr_ready, 1'b1);
        tick();
        check("nop_rv_drop", result_valid, 1'b0);

        // Illegal opcode 13
        instr       = mk(4'd13, 3'd2, 3'd1, 3'd1);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("ill_wr_t0", WR, 1'b0);
        check("ill_err_t0", err, 1'b0);
        tick();
        check("ill_err", err, 1'b1);
        check("ill_wr_t1", WR, 1'b0);
        check("ill_rv", result_valid, 1'b0);
        check("ill_ready", instr_ready, 1'b1);
        check("ill_retired", retired, 32'(exp_ret));
        tick();
        check("ill_err_drop", err, 1'b0);
        check("ill_wr_t2", WR, 1'b0);

        // Back-to-back r4 = r4 + r4 with valid held throughout
        instr       = mk(4'd1, 3'd4, 3'd4, 3'd4);
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b2b_ready_low", instr_ready, 1'b0);
            tick();
            check("b2b_z", Z, 32'd8 << k);
            tick();
            tick();
            exp_ret++;
            check("b2b_rv", result_valid, 1'b1);
            check("b2b_result", result, 32'd8 << k);
        end
        instr_valid = 1'b0;
        check("b2b_retired", retired, 32'(exp_ret));

        // DONE never arrives: err after DONE_TMO cycles in ACK
        done_en     = 1'b0;
        instr       = mk(4'd11, 3'd1, 3'd3, 3'd0);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("tmo_wr", WR, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("tmo_err_early", err, 1'b0);
            check("tmo_rv_early", result_valid, 1'b0);
            check("tmo_ready_low", instr_ready, 1'b0);
        end
        tick();
        check("tmo_err", err, 1'b1);
        check("tmo_rv", result_valid, 1'b0);
        check("tmo_ready", instr_ready, 1'b1);
        check("tmo_retired", retired, 32'(exp_ret));
        tick();
        check("tmo_err_drop", err, 1'b0);
        done_en = 1'b1;

        // Reset asserted while in WB
        instr       = mk(4'd1, 3'd2, 3'd1, 3'd2);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("rwb_wr_before", WR, 1'b1);
        rst = 1'b1;
        #1;
        check("rwb_wr", WR, 1'b0);
        check("rwb_z", Z, 32'h0);
        check("rwb_result", result, 32'h0);
        check("rwb_retired", retired, 32'h0);
        check("rwb_addr", {src1, src2, dest}, 32'h0);
        check("rwb_bank", mem[0], 32'h0);
        tick();
        rst     = 1'b0;
        exp_ret = 0;
        tick();
        check("rwb_ready", instr_ready, 1'b1);
        exec_op("post_rst_add", mk(4'd1, 3'd3, 3'd1, 3'd2), 32'h0000_0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
